// File: rtl/pwm_meter_if.sv
// Register bus shared by the PWM generator/meter family:
// 8-bit address, write data, registered read data and a write strobe.
interface pwm_meter_if;
   logic [7:0] addr;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       we;

   modport master (output addr, output data_in, output we, input data_out);
   modport slave  (input addr, input data_in, input we, output data_out);
endinterface

// File: rtl/pwm_meter.sv
// Pulse-width meter: synchronises an external pulse line and measures the
// low-phase and high-phase durations in clk cycles.
// Results are read back as 32-bit values over the 8-bit register bus.
// Map (offset from BASE_ADDR):
//   +0 CTRL   : bit0 start, bit1 continuous, bit2 clear
//   +1 STATUS : bit0 valid, bit1 busy, bit2 overflow
//   +2..+5 LOW, +6..+9 HIGH (little-endian bytes)
module pwm_meter #(
   parameter logic [7:0]  BASE_ADDR   = 8'h50,
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] MAX_COUNT   = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        res_n,
   pwm_meter_if.slave  bus,
   input  logic        in,
   output logic        valid,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARM,
      ST_LOW,
      ST_HIGH
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s, s_d;
   logic                   fall, rise;
   logic [31:0]            cnt_q, cnt_d;
   logic [31:0]            low_tmp_q, low_tmp_d;
   logic [31:0]            low_q, low_d;
   logic [31:0]            high_q, high_d;
   logic                   valid_q, valid_d;
   logic                   ovf_q, ovf_d;
   logic                   cont_q;
   logic [7:0]             off;
   logic                   mapped;
   logic                   ctrl_wr, start_w, clear_w;

   assign s    = sync_q[SYNC_STAGES-1];
   assign fall = s_d & ~s;
   assign rise = ~s_d & s;

   // Address decode; the map never wraps past 8'hFF, so the range test is exact.
   assign off     = bus.addr - BASE_ADDR;
   assign mapped  = (bus.addr >= BASE_ADDR) && (off <= 8'd9);
   assign ctrl_wr = bus.we && mapped && (off == 8'd0);
   assign start_w = ctrl_wr && bus.data_in[0];
   assign clear_w = ctrl_wr && bus.data_in[2];

   assign busy  = (state_q != ST_IDLE);
   assign valid = valid_q;

   // Input synchroniser plus one delay stage for edge detection.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         sync_q <= '0;
         s_d    <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in};
         s_d    <= s;
      end
   end

   // Continuous-mode bit; start and clear act as one-cycle strobes only.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         cont_q <= 1'b0;
      end else if (ctrl_wr) begin
         cont_q <= bus.data_in[1];
      end
   end

   // State, counters and result registers.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         low_tmp_q <= '0;
         low_q     <= '0;
         high_q    <= '0;
         valid_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         low_tmp_q <= low_tmp_d;
         low_q     <= low_d;
         high_q    <= high_d;
         valid_q   <= valid_d;
         ovf_q     <= ovf_d;
      end
   end

   // Next-state logic; a terminating edge wins over saturation, and bus
   // commands (clear, then start) override whatever the FSM would do.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      low_tmp_d = low_tmp_q;
      low_d     = low_q;
      high_d    = high_q;
      valid_d   = valid_q;
      ovf_d     = ovf_q;
      case (state_q)
         ST_IDLE: begin
         end
         ST_ARM: begin
            if (fall) begin
               state_d = ST_LOW;
               cnt_d   = 32'd1;
            end
         end
         ST_LOW: begin
            if (rise) begin
               low_tmp_d = cnt_q;
               cnt_d     = 32'd1;
               state_d   = ST_HIGH;
            end else if (cnt_q == MAX_COUNT) begin
               ovf_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_HIGH: begin
            if (fall) begin
               low_d   = low_tmp_q;
               high_d  = cnt_q;
               valid_d = 1'b1;
               if (cont_q) begin
                  state_d = ST_LOW;
                  cnt_d   = 32'd1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else if (cnt_q == MAX_COUNT) begin
               ovf_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clear_w) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
         low_d   = '0;
         high_d  = '0;
         state_d = ST_IDLE;
      end
      if (start_w) begin
         state_d = ST_ARM;
         cnt_d   = '0;
      end
   end

   // Registered read mux; unmapped addresses hold the previous value.
   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         bus.data_out <= '0;
      end else if (mapped) begin
         case (off)
            8'd0:    bus.data_out <= {6'b0, cont_q, 1'b0};
            8'd1:    bus.data_out <= {5'b0, ovf_q, busy, valid_q};
            8'd2:    bus.data_out <= low_q[7:0];
            8'd3:    bus.data_out <= low_q[15:8];
            8'd4:    bus.data_out <= low_q[23:16];
            8'd5:    bus.data_out <= low_q[31:24];
            8'd6:    bus.data_out <= high_q[7:0];
            8'd7:    bus.data_out <= high_q[15:8];
            8'd8:    bus.data_out <= high_q[23:16];
            8'd9:    bus.data_out <= high_q[31:24];
            default: bus.data_out <= bus.data_out;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_meter.sv
// Directed-plus-random bench for pwm_meter. Expected widths come from the
// durations the bench itself holds the pin at each level.
module tb_pwm_meter;

   localparam logic [7:0]  BASE = 8'h50;
   localparam int unsigned SYNC = 2;
   localparam logic [31:0] MAXC = 32'd1000;

   logic clk    = 1'b0;
   logic res_n  = 1'b0;
   logic in_pin = 1'b0;
   logic valid, busy;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   pwm_meter_if bus ();

   pwm_meter #(
      .BASE_ADDR   (BASE),
      .SYNC_STAGES (SYNC),
      .MAX_COUNT   (MAXC)
   ) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus),
      .in    (in_pin),
      .valid (valid),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #(10 * 60000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic phase(input logic lvl, input int unsigned n);
      in_pin = lvl;
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int unsigned off, input logic [7:0] d);
      bus.addr    = BASE + 8'(off);
      bus.data_in = d;
      bus.we      = 1'b1;
      tick();
      bus.we      = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [7:0] d);
      bus.addr = a;
      tick();
      d = bus.data_out;
   endtask

   task automatic rd32(input int unsigned off, output logic [31:0] v);
      logic [7:0] b;
      for (int i = 0; i < 4; i++) begin
         rd(BASE + 8'(off + i), b);
         v[8*i +: 8] = b;
      end
   endtask

   task automatic chk_results(input string tag, input logic [31:0] elo, input logic [31:0] ehi);
      logic [31:0] lo, hi;
      rd32(2, lo);
      rd32(6, hi);
      chk({tag, "_low"}, lo, elo);
      chk({tag, "_high"}, hi, ehi);
   endtask

   // Low phase of n cycles (n >= 12) that also checks the period just ended.
   task automatic low_and_check(input int unsigned n, input logic [31:0] elo,
                                input logic [31:0] ehi, input string tag);
      in_pin = 1'b0;
      repeat (SYNC + 1) tick();
      chk({tag, "_valid"}, valid, 1'b1);
      chk({tag, "_busy"}, busy, 1'b1);
      chk_results(tag, elo, ehi);
      repeat (n - (SYNC + 1) - 8) tick();
   endtask

   initial begin
      logic [7:0]  b;
      int unsigned lo_a [5];
      int unsigned hi_a [5];
      int unsigned t;

      bus.addr    = '0;
      bus.data_in = '0;
      bus.we      = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_dout", bus.data_out, 8'h00);
      res_n = 1'b1;
      tick();

      // CTRL readback, unmapped reads, read-only writes
      wr(0, 8'hFA);
      rd(BASE, b);
      chk("ctrl_rb", b, 8'h02);
      rd(8'h10, b);
      chk("unmapped_low_hold", b, 8'h02);
      rd(BASE + 8'd10, b);
      chk("unmapped_high_hold", b, 8'h02);
      wr(1, 8'hFF);
      rd(BASE + 8'd1, b);
      chk("ro_write_ignored", b, 8'h00);
      chk("ro_write_busy", busy, 1'b0);
      wr(0, 8'h00);
      rd(BASE, b);
      chk("ctrl_rb0", b, 8'h00);

      // Single 250/250 measurement with latency check
      wr(0, 8'h01);
      chk("single_busy", busy, 1'b1);
      phase(1'b1, 5);
      phase(1'b0, 250);
      phase(1'b1, 250);
      in_pin = 1'b0;
      repeat (SYNC) tick();
      chk("single_valid_early", valid, 1'b0);
      tick();
      chk("single_valid", valid, 1'b1);
      chk("single_idle", busy, 1'b0);
      chk_results("single", 32'd250, 32'd250);

      // Reset mid-measurement while in the high phase
      wr(0, 8'h01);
      phase(1'b1, 5);
      phase(1'b0, 20);
      phase(1'b1, 10);
      res_n = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_valid", valid, 1'b0);
      chk("mid_rst_dout", bus.data_out, 8'h00);
      #1;
      res_n = 1'b1;
      phase(1'b0, 10);
      phase(1'b1, 10);
      phase(1'b0, 10);
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_valid", valid, 1'b0);
      for (int i = 0; i < 10; i++) begin
         rd(BASE + 8'(i), b);
         chk($sformatf("post_rst_reg%0d", i), b, 8'h00);
      end

      // Continuous mode: loopback-like 250/250 then random periods;
      // the continuous bit is dropped during the last high phase.
      lo_a[0] = 250;
      hi_a[0] = 250;
      for (int i = 1; i < 5; i++) begin
         lo_a[i] = $urandom_range(12, 60);
         hi_a[i] = (i == 4) ? $urandom_range(10, 60) : $urandom_range(1, 60);
      end
      wr(0, 8'h03);
      phase(1'b1, 5);
      for (int i = 0; i < 5; i++) begin
         if (i == 0) phase(1'b0, lo_a[0]);
         else low_and_check(lo_a[i], lo_a[i-1], hi_a[i-1], $sformatf("cont_p%0d", i - 1));
         if (i < 4) begin
            phase(1'b1, hi_a[i]);
         end else begin
            in_pin = 1'b1;
            repeat (5) tick();
            wr(0, 8'h00);
            chk("cont_off_busy", busy, 1'b1);
            repeat (hi_a[i] - 6) tick();
         end
      end
      in_pin = 1'b0;
      repeat (SYNC + 1) tick();
      chk("cont_last_valid", valid, 1'b1);
      chk("cont_last_idle", busy, 1'b0);
      chk_results("cont_p4", lo_a[4], hi_a[4]);

      // Restart while in the high phase, then a clean 10/20 period
      wr(0, 8'h01);
      phase(1'b1, 5);
      phase(1'b0, 17);
      in_pin = 1'b1;
      repeat (8) tick();
      wr(0, 8'h01);
      chk("restart_busy", busy, 1'b1);
      chk("restart_valid_kept", valid, 1'b1);
      chk_results("restart_kept", lo_a[4], hi_a[4]);
      phase(1'b0, 10);
      phase(1'b1, 20);
      in_pin = 1'b0;
      repeat (SYNC + 1) tick();
      chk("restart_valid", valid, 1'b1);
      chk_results("restart", 32'd10, 32'd20);

      // Clear and start in one write, then a 3/7 period
      wr(0, 8'h05);
      chk("clrstart_valid", valid, 1'b0);
      chk("clrstart_busy", busy, 1'b1);
      rd(BASE + 8'd1, b);
      chk("clrstart_status", b, 8'h02);
      chk_results("clrstart", 32'd0, 32'd0);
      phase(1'b1, 5);
      phase(1'b0, 3);
      phase(1'b1, 7);
      in_pin = 1'b0;
      repeat (SYNC + 1) tick();
      chk("p37_valid", valid, 1'b1);
      chk_results("p37", 32'd3, 32'd7);

      // Overflow: low held past MAX_COUNT. The counter holds MAXC low cycles;
      // the next low cycle saturates, so busy drops SYNC+1+MAXC cycles
      // after the pin falls.
      wr(0, 8'h04);
      chk("clr_busy", busy, 1'b0);
      wr(0, 8'h01);
      phase(1'b1, 5);
      in_pin = 1'b0;
      t = 0;
      do begin
         tick();
         t++;
      end while (busy && t < 1200);
      chk("ovf_latency", t, SYNC + 1 + MAXC);
      chk("ovf_valid", valid, 1'b0);
      rd(BASE + 8'd1, b);
      chk("ovf_status", b, 8'h04);
      chk_results("ovf", 32'd0, 32'd0);

      // A DC level in ARM waits without overflow
      wr(0, 8'h01);
      phase(1'b0, 1100);
      chk("arm_dc_busy", busy, 1'b1);
      rd(BASE + 8'd1, b);
      chk("arm_dc_status", b, 8'h06);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
